// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: per-channel divided level and strobe,
// shadowed divisor applied at period boundaries, shared sync for phase alignment.
module clk_divider_multi #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned W       = 32,
  parameter int unsigned DEF_DIV = 20
) (
  input  logic                I_CLK,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   en,
  input  logic                sync,
  input  logic [NUM_CH-1:0]   div_wr,
  input  logic [NUM_CH*W-1:0] div_in,
  output logic [NUM_CH-1:0]   O_CLK,
  output logic [NUM_CH-1:0]   O_TICK
);

  logic [W-1:0]      cnt     [NUM_CH];
  logic [W-1:0]      div_sh  [NUM_CH];
  logic [W-1:0]      div_act [NUM_CH];
  logic [W-1:0]      n_eff   [NUM_CH];
  logic [W-1:0]      hi      [NUM_CH];
  logic [W-1:0]      div_nxt [NUM_CH];
  logic [NUM_CH-1:0] last_c;

  // Effective divisor (0/1 clamp to 2), high-phase length, boundary detect, next divisor
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      n_eff[i]   = (div_act[i] < W'(2)) ? W'(2) : div_act[i];
      hi[i]      = W'(({1'b0, n_eff[i]} + (W+1)'(1)) >> 1);
      last_c[i]  = (cnt[i] >= (n_eff[i] - W'(1)));
      div_nxt[i] = div_wr[i] ? div_in[i*W +: W] : div_sh[i];
    end
  end

  always_ff @(posedge I_CLK) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]     <= '0;
        div_sh[i]  <= W'(DEF_DIV);
        div_act[i] <= W'(DEF_DIV);
      end
      O_CLK  <= '0;
      O_TICK <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (div_wr[i]) begin
          div_sh[i] <= div_in[i*W +: W];
        end
        if (!en[i]) begin
          cnt[i]     <= '0;
          O_CLK[i]   <= 1'b0;
          O_TICK[i]  <= 1'b0;
          div_act[i] <= div_nxt[i];
        end else if (sync) begin
          cnt[i]     <= '0;
          O_CLK[i]   <= 1'b1;
          O_TICK[i]  <= 1'b0;
          div_act[i] <= div_nxt[i];
        end else begin
          // ">=" in last_c also pulls cnt back if the divisor shrank under it
          cnt[i]    <= last_c[i] ? '0 : cnt[i] + W'(1);
          O_CLK[i]  <= (cnt[i] < hi[i]);
          O_TICK[i] <= last_c[i];
          if (last_c[i]) begin
            div_act[i] <= div_nxt[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: vector table, directed multi-cycle scenarios and
// randomized traffic checked against a cycle-level reference model.
module tb_clk_divider_multi;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned W      = 32;

  logic                I_CLK = 1'b0;
  logic                rst   = 1'b1;
  logic                sync  = 1'b0;
  logic [NUM_CH-1:0]   en     = '0;
  logic [NUM_CH-1:0]   div_wr = '0;
  logic [NUM_CH*W-1:0] div_in = '0;
  logic [NUM_CH-1:0]   O_CLK;
  logic [NUM_CH-1:0]   O_TICK;

  int n_tests = 0;
  int n_fail  = 0;
  bit model_on = 1'b0;

  always #5 I_CLK = ~I_CLK;

  clk_divider_multi #(.NUM_CH(NUM_CH), .W(W), .DEF_DIV(20)) dut (
    .I_CLK (I_CLK),
    .rst   (rst),
    .en    (en),
    .sync  (sync),
    .div_wr(div_wr),
    .div_in(div_in),
    .O_CLK (O_CLK),
    .O_TICK(O_TICK)
  );

  // Reference model: position within the period, divisor shadow/active pair
  longint unsigned m_cnt [NUM_CH];
  longint unsigned m_sh  [NUM_CH];
  longint unsigned m_act [NUM_CH];
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_tick;

  always @(posedge I_CLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      longint unsigned n, hi, nxt;
      if (rst) begin
        m_cnt[i] = 0; m_clk[i] = 1'b0; m_tick[i] = 1'b0;
        m_sh[i] = 20; m_act[i] = 20;
      end else begin
        n   = (m_act[i] < 2) ? 2 : m_act[i];
        hi  = (n + 1) / 2;
        nxt = div_wr[i] ? 64'(div_in[i*W +: W]) : m_sh[i];
        if (div_wr[i]) m_sh[i] = nxt;
        if (!en[i]) begin
          m_cnt[i] = 0; m_clk[i] = 1'b0; m_tick[i] = 1'b0; m_act[i] = nxt;
        end else if (sync) begin
          m_cnt[i] = 0; m_clk[i] = 1'b1; m_tick[i] = 1'b0; m_act[i] = nxt;
        end else begin
          m_clk[i]  = (m_cnt[i] < hi);
          m_tick[i] = (m_cnt[i] + 1 >= n);
          if (m_cnt[i] + 1 >= n) begin
            m_cnt[i] = 0;
            m_act[i] = nxt;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
      end
    end
  end

  always @(negedge I_CLK) begin
    if (model_on) begin
      n_tests++;
      if (O_CLK !== m_clk || O_TICK !== m_tick) begin
        n_fail++;
        $display("FAIL model t=%0t O_CLK=%b exp=%b O_TICK=%b exp=%b",
                 $time, O_CLK, m_clk, O_TICK, m_tick);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge I_CLK);
    #1;
  endtask

  task automatic set_div(input int ch, input logic [W-1:0] val);
    div_in[ch*W +: W] = val;
  endtask

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic [NUM_CH-1:0] wr;
    logic [W-1:0]      din;
    logic [NUM_CH-1:0] exp_clk;
    logic [NUM_CH-1:0] exp_tick;
  } vec_t;

  vec_t vecs [12];
  int   errs;

  initial begin
    // All channels in lockstep at N=3 (high 2, low 1), then a sync, then disable
    vecs[0]  = '{4'h0, 1'b0, 4'hF, 32'd3, 4'h0, 4'h0};
    vecs[1]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'hF, 4'h0};
    vecs[2]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'hF, 4'h0};
    vecs[3]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'h0, 4'hF};
    vecs[4]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'hF, 4'h0};
    vecs[5]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'hF, 4'h0};
    vecs[6]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'h0, 4'hF};
    vecs[7]  = '{4'hF, 1'b1, 4'h0, 32'd3, 4'hF, 4'h0};
    vecs[8]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'hF, 4'h0};
    vecs[9]  = '{4'hF, 1'b0, 4'h0, 32'd3, 4'hF, 4'h0};
    vecs[10] = '{4'hF, 1'b0, 4'h0, 32'd3, 4'h0, 4'hF};
    vecs[11] = '{4'h0, 1'b0, 4'h0, 32'd3, 4'h0, 4'h0};

    rst = 1'b1;
    cyc(); cyc();
    model_on = 1'b1;
    check("reset_clk", 32'(O_CLK), 32'h0);
    check("reset_tick", 32'(O_TICK), 32'h0);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      en = vecs[r].en; sync = vecs[r].sync; div_wr = vecs[r].wr;
      for (int c = 0; c < int'(NUM_CH); c++) set_div(c, vecs[r].din);
      cyc();
      check($sformatf("vec%0d_clk", r), 32'(O_CLK), 32'(vecs[r].exp_clk));
      check($sformatf("vec%0d_tick", r), 32'(O_TICK), 32'(vecs[r].exp_tick));
    end
    sync = 1'b0; div_wr = '0;

    // Default divisor after reset: period 20, high 10
    rst = 1'b1; en = '0; cyc();
    check("t1_rst_clk", 32'(O_CLK), 32'h0);
    rst = 1'b0; en[0] = 1'b1;
    errs = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (O_CLK[0] !== ((k % 20) < 10) || O_TICK[0] !== ((k % 20) == 19)) errs++;
    end
    check("t1_div20_errs", 32'(errs), 32'h0);

    // Odd divisor 5 on ch1: 1,1,1,0,0 with tick on the second low cycle
    set_div(1, 32'd5); div_wr[1] = 1'b1; cyc();
    div_wr[1] = 1'b0; en[1] = 1'b1;
    errs = 0;
    for (int k = 0; k < 15; k++) begin
      cyc();
      if (O_CLK[1] !== ((k % 5) < 3) || O_TICK[1] !== ((k % 5) == 4)) errs++;
    end
    check("t2_div5_errs", 32'(errs), 32'h0);

    // Mid-period write on ch0 waits for the period boundary
    en[0] = 1'b0; cyc(); en[0] = 1'b1;
    errs = 0;
    for (int k = 0; k < 36; k++) begin
      if (k == 3) begin set_div(0, 32'd8); div_wr[0] = 1'b1; end
      else div_wr[0] = 1'b0;
      cyc();
      if (k < 20) begin
        if (O_CLK[0] !== (k < 10) || O_TICK[0] !== (k == 19)) errs++;
      end else begin
        if (O_CLK[0] !== (((k - 20) % 8) < 4) || O_TICK[0] !== (((k - 20) % 8) == 7)) errs++;
      end
    end
    div_wr[0] = 1'b0;
    check("t3_shadow_errs", 32'(errs), 32'h0);

    // Divisors 0 and 1 clamp to 2
    for (int d = 0; d < 2; d++) begin
      en[2] = 1'b0; set_div(2, 32'(d)); div_wr[2] = 1'b1; cyc();
      div_wr[2] = 1'b0; en[2] = 1'b1;
      errs = 0;
      for (int k = 0; k < 8; k++) begin
        cyc();
        if (O_CLK[2] !== ((k % 2) == 0) || O_TICK[2] !== ((k % 2) == 1)) errs++;
      end
      check($sformatf("t4_clamp%0d_errs", d), 32'(errs), 32'h0);
    end

    // Sync aligns ch0 (N=4) and ch1 (N=6): joint rises every 12 cycles
    en[1:0] = 2'b00; set_div(0, 32'd4); set_div(1, 32'd6); div_wr[1:0] = 2'b11; cyc();
    div_wr[1:0] = 2'b00; en[1:0] = 2'b11;
    repeat (7) cyc();
    sync = 1'b1; cyc(); sync = 1'b0;
    check("t5_sync_clk", 32'(O_CLK[1:0]), 32'h3);
    errs = 0;
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (O_CLK[0] !== (((k - 1) % 4) < 2) || O_CLK[1] !== (((k - 1) % 6) < 3)) errs++;
      if (k == 13 || k == 25) check($sformatf("t5_corise%0d", k), 32'(O_CLK[1:0]), 32'h3);
    end
    check("t5_align_errs", 32'(errs), 32'h0);

    // Reset mid-period restores DEF_DIV
    en[0] = 1'b0; set_div(0, 32'd8); div_wr[0] = 1'b1; cyc();
    div_wr[0] = 1'b0; en[0] = 1'b1;
    repeat (11) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    check("t6_rst_clk", 32'(O_CLK), 32'h0);
    check("t6_rst_tick", 32'(O_TICK), 32'h0);
    errs = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (O_CLK[0] !== ((k % 20) < 10) || O_TICK[0] !== ((k % 20) == 19)) errs++;
    end
    check("t6_div20_errs", 32'(errs), 32'h0);

    // Randomized traffic, checked every cycle by the model
    en = 4'hF;
    for (int k = 0; k < 600; k++) begin
      rst    = ($urandom_range(0, 149) == 0);
      sync   = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) en = 4'($urandom);
      div_wr = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      for (int c = 0; c < int'(NUM_CH); c++) set_div(c, 32'($urandom_range(0, 9)));
      cyc();
    end
    rst = 1'b0; sync = 1'b0; div_wr = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
